// File: rtl/dataframe_capture_buffer.sv
// Circular capture buffer for uplink frames with immediate or triggered capture
// and a registered word-select read port addressed by logical frame index.
module dataframe_capture_buffer #(
  parameter  int FRAME_W = 234,
  parameter  int WORD_W  = 32,
  parameter  int DEPTH   = 64,
  localparam int AW      = $clog2(DEPTH),
  localparam int NW      = (FRAME_W + WORD_W - 1) / WORD_W,
  localparam int WSW     = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic               clk40_i,
  input  logic               rst_i,
  input  logic [FRAME_W-1:0] frame_i,
  input  logic               frame_valid_i,
  input  logic               mode_i,
  input  logic [AW-1:0]      pretrig_i,
  input  logic               arm_i,
  input  logic               trig_i,
  input  logic               rd_en_i,
  input  logic [AW-1:0]      rd_frame_i,
  input  logic [WSW-1:0]     rd_word_i,
  output logic [WORD_W-1:0]  rd_data_o,
  output logic               rd_valid_o,
  output logic [2:0]         state_o,
  output logic               done_o,
  output logic [AW-1:0]      start_ptr_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    PRE  = 3'd2,
    WAIT = 3'd3,
    POST = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  state_t              state, state_nxt;
  logic [AW-1:0]       wr_ptr;
  logic [AW:0]         cnt;
  logic [AW:0]         cnt_inc;
  logic [AW:0]         post_target;
  logic [AW-1:0]       pretrig_q;
  logic                wr_en;
  logic [AW-1:0]       rd_addr;

  logic [FRAME_W-1:0]  mem [DEPTH];
  logic [FRAME_W-1:0]  rd_frame_q;
  logic [WSW-1:0]      rd_word_q;
  logic                rd_loaded;
  logic [NW*WORD_W-1:0] padded;

  assign cnt_inc     = cnt + (AW+1)'(1);
  assign post_target = DEPTH_C - {1'b0, pretrig_q};
  assign wr_en       = frame_valid_i &&
                       (state inside {FILL, PRE, WAIT, POST});
  assign rd_addr     = start_ptr_o + rd_frame_i;

  // State register.
  always_ff @(posedge clk40_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; the state itself remembers the latched capture mode.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (arm_i)
                    state_nxt = !mode_i             ? FILL :
                                (pretrig_i == '0)   ? WAIT : PRE;
      FILL: if (frame_valid_i && cnt_inc == DEPTH_C)              state_nxt = DONE;
      PRE:  if (frame_valid_i && cnt_inc == {1'b0, pretrig_q})    state_nxt = WAIT;
      WAIT: if (trig_i)
              state_nxt = (frame_valid_i && post_target == (AW+1)'(1)) ? DONE : POST;
      POST: if (frame_valid_i && cnt_inc == post_target)          state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    state_o = state;
    done_o  = (state == DONE);
  end

  // Capture datapath: write pointer, phase counter, pretrigger and start pointer.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk40_i) begin
    if (rst_i) begin
      wr_ptr      <= '0;
      cnt         <= '0;
      pretrig_q   <= '0;
      start_ptr_o <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      case (state)
        IDLE, DONE: if (arm_i) begin
          pretrig_q <= pretrig_i;
          wr_ptr    <= '0;
          cnt       <= '0;
        end
        FILL: if (frame_valid_i) begin
          cnt <= cnt_inc;
          if (cnt_inc == DEPTH_C) start_ptr_o <= '0;
        end
        PRE: if (frame_valid_i)
          cnt <= (cnt_inc == {1'b0, pretrig_q}) ? '0 : cnt_inc;
        WAIT: if (trig_i) begin
          // The trigger-cycle frame (if valid) is the first post-trigger frame.
          start_ptr_o <= wr_ptr - pretrig_q;
          cnt         <= frame_valid_i ? (AW+1)'(1) : '0;
        end
        POST: if (frame_valid_i) cnt <= cnt_inc;
        default: ;
      endcase
    end
  end

  // Frame store: one write port, one registered read port (old data on collision).
  // NOTE: the memory has no reset so it maps onto block RAM.
  always_ff @(posedge clk40_i) begin
    if (wr_en)   mem[wr_ptr] <= frame_i;
    if (rd_en_i) rd_frame_q  <= mem[rd_addr];
  end

  always_ff @(posedge clk40_i) begin
    if (rst_i) begin
      rd_valid_o <= 1'b0;
      rd_word_q  <= '0;
      rd_loaded  <= 1'b0;
    end else begin
      rd_valid_o <= rd_en_i;
      if (rd_en_i) begin
        rd_word_q <= rd_word_i;
        rd_loaded <= 1'b1;
      end
    end
  end

  // Word select on the registered frame; zero before the first read after reset.
  always_comb begin
    padded                = '0;
    padded[FRAME_W-1:0]   = rd_frame_q;
    rd_data_o             = '0;
    if (rd_loaded && int'(rd_word_q) < NW)
      rd_data_o = padded[int'(rd_word_q)*WORD_W +: WORD_W];
  end

endmodule

// File: tb/tb_dataframe_capture_buffer.sv
// Directed bench for dataframe_capture_buffer at DEPTH = 8; a second instance
// with 48-bit words covers the out-of-range word index.
module tb_dataframe_capture_buffer;

  localparam int FW = 234;
  localparam int D  = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [FW-1:0]  frame;
  logic           valid;
  logic           mode;
  logic [2:0]     pretrig;
  logic           arm;
  logic           trig;
  logic           rd_en;
  logic [2:0]     rd_frame;
  logic [2:0]     rd_word;

  logic [31:0]    rd_data;
  logic           rd_valid;
  logic [2:0]     state;
  logic           done;
  logic [2:0]     start_ptr;

  logic [47:0]    rd_data2;
  logic           rd_valid2;
  logic [2:0]     state2;
  logic           done2;
  logic [2:0]     start_ptr2;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dataframe_capture_buffer #(.FRAME_W(FW), .WORD_W(32), .DEPTH(D)) dut (
    .clk40_i(clk), .rst_i(rst), .frame_i(frame), .frame_valid_i(valid),
    .mode_i(mode), .pretrig_i(pretrig), .arm_i(arm), .trig_i(trig),
    .rd_en_i(rd_en), .rd_frame_i(rd_frame), .rd_word_i(rd_word),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .state_o(state),
    .done_o(done), .start_ptr_o(start_ptr)
  );

  dataframe_capture_buffer #(.FRAME_W(FW), .WORD_W(48), .DEPTH(D)) dut48 (
    .clk40_i(clk), .rst_i(rst), .frame_i(frame), .frame_valid_i(valid),
    .mode_i(mode), .pretrig_i(pretrig), .arm_i(arm), .trig_i(trig),
    .rd_en_i(rd_en), .rd_frame_i(rd_frame), .rd_word_i(rd_word),
    .rd_data_o(rd_data2), .rd_valid_o(rd_valid2), .state_o(state2),
    .done_o(done2), .start_ptr_o(start_ptr2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int f, input logic v, input logic t);
    frame = FW'(f);
    valid = v;
    trig  = t;
    tick();
    valid = 1'b0;
    trig  = 1'b0;
  endtask

  task automatic do_arm(input logic m, input logic [2:0] p);
    mode    = m;
    pretrig = p;
    arm     = 1'b1;
    tick();
    arm     = 1'b0;
  endtask

  task automatic rd(input string tag, input int f, input int w, input logic [63:0] exp);
    rd_en    = 1'b1;
    rd_frame = 3'(f);
    rd_word  = 3'(w);
    tick();
    rd_en    = 1'b0;
    check({tag, "_valid"}, 64'(rd_valid), 64'd1);
    check(tag, 64'(rd_data), exp);
  endtask

  initial begin
    rst = 1'b1; frame = '0; valid = 1'b0; mode = 1'b0; pretrig = '0;
    arm = 1'b0; trig = 1'b0; rd_en = 1'b0; rd_frame = '0; rd_word = '0;
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_state",     64'(state),     64'd0);
    check("rst_done",      64'(done),      64'd0);
    check("rst_start_ptr", 64'(start_ptr), 64'd0);
    check("rst_rd_valid",  64'(rd_valid),  64'd0);
    check("rst_rd_data",   64'(rd_data),   64'd0);

    // Immediate fill: frames 1..10, only 1..8 kept
    do_arm(1'b0, 3'd0);
    check("fill_state", 64'(state), 64'd1);
    for (int n = 1; n <= 10; n++) begin
      put(n, 1'b1, 1'b0);
      if (n == 7) check("fill_not_done_7", 64'(done), 64'd0);
      if (n == 8) check("fill_done_8",     64'(done), 64'd1);
    end
    check("fill_state_done", 64'(state),     64'd5);
    check("fill_start_ptr",  64'(start_ptr), 64'd0);
    rd("fill_f3w0", 3, 0, 64'd4);
    rd("fill_f7w0", 7, 0, 64'd8);
    tick();
    check("fill_valid_drop", 64'(rd_valid), 64'd0);
    check("fill_data_hold",  64'(rd_data),  64'd8);

    // Word select and zero padding with an all-ones frame at logical 0
    do_arm(1'b0, 3'd0);
    frame = '1; valid = 1'b1; tick(); valid = 1'b0;
    for (int n = 2; n <= 8; n++) put(n, 1'b1, 1'b0);
    check("pad_done", 64'(done), 64'd1);
    rd("pad_w0", 0, 0, 64'hFFFF_FFFF);
    rd("pad_w7", 0, 7, 64'h0000_03FF);
    rd("pad_w4", 0, 4, 64'hFFFF_FFFF);
    check("pad48_w4", 64'(rd_data2), 64'h03FF_FFFF_FFFF);
    rd("pad_w5", 0, 5, 64'hFFFF_FFFF);
    check("pad48_w5_oob", 64'(rd_data2), 64'd0);

    // Triggered capture with wrap: pretrig 3, trigger on frame 12
    do_arm(1'b1, 3'd3);
    check("trg_state_pre", 64'(state), 64'd2);
    for (int n = 1; n <= 20; n++) begin
      put(n, 1'b1, n == 12);
      if (n == 3)  check("trg_wait_3",  64'(state), 64'd3);
      if (n == 11) check("trg_wait_11", 64'(state), 64'd3);
      if (n == 12) check("trg_post_12", 64'(state), 64'd4);
      if (n == 15) check("trg_post_15", 64'(state), 64'd4);
      if (n == 16) check("trg_done_16", 64'(done),  64'd1);
    end
    check("trg_start_ptr", 64'(start_ptr), 64'd0);
    for (int i = 0; i < 8; i++) rd($sformatf("trg_f%0d", i), i, 0, 64'(9 + i));

    // Valid gaps, early trigger in PRE, arm ignored in WAIT
    do_arm(1'b1, 3'd3);
    put(101, 1'b1, 1'b0);
    put(0,   1'b0, 1'b1);
    check("gap_trig_in_pre", 64'(state), 64'd2);
    put(102, 1'b1, 1'b0);
    put(0,   1'b0, 1'b0);
    check("gap_pre_stall", 64'(state), 64'd2);
    put(103, 1'b1, 1'b0);
    check("gap_to_wait", 64'(state), 64'd3);
    put(104, 1'b1, 1'b0);
    do_arm(1'b0, 3'd5);
    check("gap_arm_in_wait", 64'(state), 64'd3);
    put(105, 1'b1, 1'b0);
    put(0,   1'b0, 1'b1);
    check("gap_post", 64'(state), 64'd4);
    put(106, 1'b1, 1'b0);
    put(0,   1'b0, 1'b0);
    put(107, 1'b1, 1'b0);
    put(108, 1'b1, 1'b0);
    put(0,   1'b0, 1'b0);
    put(109, 1'b1, 1'b0);
    check("gap_post_4", 64'(state), 64'd4);
    put(110, 1'b1, 1'b0);
    check("gap_done",      64'(done),      64'd1);
    check("gap_start_ptr", 64'(start_ptr), 64'd2);
    rd("gap_f0", 0, 0, 64'd103);
    rd("gap_f3", 3, 0, 64'd106);
    rd("gap_f7", 7, 0, 64'd110);

    // Pretrig 0 goes straight to WAIT; reset during POST
    do_arm(1'b1, 3'd0);
    check("rst_t_wait", 64'(state), 64'd3);
    put(201, 1'b1, 1'b0);
    put(202, 1'b1, 1'b1);
    check("rst_t_post", 64'(state), 64'd4);
    put(203, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_state",     64'(state),     64'd0);
    check("mid_rst_done",      64'(done),      64'd0);
    check("mid_rst_start_ptr", 64'(start_ptr), 64'd0);

    // Re-arm with trig in the same cycle: arm wins, trigger ignored
    mode = 1'b1; pretrig = 3'd2; arm = 1'b1; trig = 1'b1;
    tick();
    arm = 1'b0; trig = 1'b0;
    check("rearm_pre", 64'(state), 64'd2);
    put(301, 1'b1, 1'b0);
    put(302, 1'b1, 1'b0);
    check("rearm_wait", 64'(state), 64'd3);
    put(303, 1'b1, 1'b0);
    put(304, 1'b1, 1'b1);
    for (int n = 305; n <= 308; n++) put(n, 1'b1, 1'b0);
    check("rearm_post", 64'(state), 64'd4);
    put(309, 1'b1, 1'b0);
    check("rearm_done",      64'(done),      64'd1);
    check("rearm_start_ptr", 64'(start_ptr), 64'd1);
    rd("rearm_f0", 0, 0, 64'd302);
    rd("rearm_f7", 7, 0, 64'd309);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
